tx_8b10b_line_monitor: RTL

TX_8B10B_LINE_MONITOR -- requirements
Module: tx_8b10b_line_monitor

---
 rtl/tx_8b10b_line_monitor.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tx_8b10b_line_monitor.sv
// ---------------------------------------------------------------------------
// tx_8b10b_line_monitor
//   Watches the parallel 10-bit symbol stream feeding an 8b/10b serializer
//   and flags line-level violations: running-disparity errors, over-long
//   runs of identical bits (within a symbol and across symbol boundaries)
//   and unexpected comma-length runs in non-comma symbols.
//   Error pulses, running disparity, sticky flag and counter are registered;
//   all outputs follow the sampled symbol by one BitCLK_10 cycle.
// ---------------------------------------------------------------------------
module tx_8b10b_line_monitor #(
  parameter int MAX_RUN   = 5,
  parameter int CNT_W     = 16,
  parameter int COMMA_CHK = 1
) (
  input  logic             BitCLK_10,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [9:0]       TxParallel_10,
  input  logic [7:0]       TxParallel_8,
  input  logic             TxDataK,
  input  logic             Clear,
  output logic             RunErr,
  output logic             DispErr,
  output logic             CommaErr,
  output logic             ErrSticky,
  output logic             RD,
  output logic [CNT_W-1:0] ErrCount,
  output logic             Active
);

  // Run-length register just wide enough to hold MAX_RUN+1 (the first
  // illegal length); it saturates there so long runs never wrap.
  localparam int                 RUN_W   = $clog2(MAX_RUN + 2);
  localparam logic [RUN_W-1:0]   RUN_MAX = RUN_W'(MAX_RUN);
  localparam logic [RUN_W-1:0]   RUN_SAT = RUN_W'(MAX_RUN + 1);
  localparam logic [CNT_W-1:0]   CNT_SAT = {CNT_W{1'b1}};

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Number of ones in a 10-bit symbol (0..10).
  function automatic logic [3:0] ones_count(input logic [9:0] sym);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'b000, sym[i]};
    end
    return n;
  endfunction

  // Saturating increment of the run-length counter.
  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
    return (v >= RUN_SAT) ? RUN_SAT : (v + RUN_W'(1));
  endfunction

  // K28.1 / K28.5 / K28.7 are the only symbols allowed to carry a comma run.
  function automatic logic is_k28_comma(input logic k, input logic [7:0] b);
    return k & ((b == 8'h3C) | (b == 8'hBC) | (b == 8'hFC));
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t             state_r;
  logic               active_r;
  logic               rd_r;
  logic [RUN_W-1:0]   run_len_r;
  logic               last_bit_r;
  logic               carry_vld_r;
  logic               run_err_r;
  logic               disp_err_r;
  logic               comma_err_r;
  logic               sticky_r;
  logic [CNT_W-1:0]   err_cnt_r;

  // ---------------------------------------------------------------------
  // Combinational symbol analysis
  // ---------------------------------------------------------------------
  logic [3:0]         ones_s;
  logic               disp_err_s;
  logic               rd_next_s;
  logic [9:0]         same_s;
  logic [9:0]         run_end_s;
  logic [RUN_W-1:0]   run_s;
  logic               inherit_s;
  logic               run_err_s;
  logic               comma_hit_s;
  logic               comma_err_s;
  logic               any_err_s;

  assign ones_s = ones_count(TxParallel_10);

  // same_s[i]: bit i repeats the bit transmitted just before it. For bit 0
  // that is the last bit of the previous enabled symbol, if there was one.
  assign same_s = ~(TxParallel_10 ^ {TxParallel_10[8:0], last_bit_r})
                  & {9'h1FF, carry_vld_r};

  // run_end_s[i]: bit i is the last bit of a run inside this symbol. Bit 9
  // always closes the symbol's view of its last run.
  assign run_end_s = {1'b1, TxParallel_10[9:1] ^ TxParallel_10[8:0]};

  // Running-disparity check; d = 2*ones - 10, so ones 5/6/4 mean d 0/+2/-2.
  always_comb begin
    disp_err_s = 1'b0;
    rd_next_s  = rd_r;
    case (ones_s)
      4'd5: begin
        disp_err_s = 1'b0;
        rd_next_s  = rd_r;
      end
      4'd6: begin
        disp_err_s = rd_r;
        rd_next_s  = 1'b1;
      end
      4'd4: begin
        disp_err_s = ~rd_r;
        rd_next_s  = 1'b0;
      end
      default: begin
        disp_err_s = 1'b1;
        rd_next_s  = rd_r;
      end
    endcase
  end

  // Walk the symbol in transmit order tracking the current run length and
  // whether that run started in an earlier symbol; a comma-length run only
  // counts when it began inside this symbol.
  always_comb begin
    run_s       = run_len_r;
    inherit_s   = 1'b1;
    run_err_s   = 1'b0;
    comma_hit_s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (same_s[i]) begin
        run_s = run_inc(run_s);
      end else begin
        run_s     = RUN_W'(1);
        inherit_s = 1'b0;
      end
      run_err_s   = run_err_s | (run_s > RUN_MAX);
      comma_hit_s = comma_hit_s
                    | (run_end_s[i] & ~inherit_s & (run_s == RUN_MAX));
    end
  end

  assign comma_err_s = (COMMA_CHK != 0) & comma_hit_s
                       & ~is_k28_comma(TxDataK, TxParallel_8);
  assign any_err_s   = run_err_s | disp_err_s | comma_err_s;

  // ---------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------

  // Two-state activity FSM: leaves IDLE on the first enabled symbol.
  always_ff @(posedge BitCLK_10) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      active_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Enable) begin
            state_r  <= ST_ACTIVE;
            active_r <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            active_r <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          state_r  <= ST_ACTIVE;
          active_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_IDLE;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  // Line state (disparity, carried run) and one-cycle error pulses.
  always_ff @(posedge BitCLK_10) begin
    if (Reset) begin
      rd_r        <= 1'b0;
      run_len_r   <= '0;
      last_bit_r  <= 1'b0;
      carry_vld_r <= 1'b0;
      run_err_r   <= 1'b0;
      disp_err_r  <= 1'b0;
      comma_err_r <= 1'b0;
    end else if (Enable) begin
      rd_r        <= rd_next_s;
      run_len_r   <= run_s;
      last_bit_r  <= TxParallel_10[9];
      carry_vld_r <= 1'b1;
      run_err_r   <= run_err_s;
      disp_err_r  <= disp_err_s;
      comma_err_r <= comma_err_s;
    end else begin
      rd_r        <= rd_r;
      run_len_r   <= run_len_r;
      last_bit_r  <= last_bit_r;
      carry_vld_r <= carry_vld_r;
      run_err_r   <= 1'b0;
      disp_err_r  <= 1'b0;
      comma_err_r <= 1'b0;
    end
  end

  // Sticky flag and saturating per-symbol error counter; a new error in the
  // same cycle as Clear leaves a count of one.
  always_ff @(posedge BitCLK_10) begin
    if (Reset) begin
      sticky_r  <= 1'b0;
      err_cnt_r <= '0;
    end else if (Enable && any_err_s) begin
      sticky_r <= 1'b1;
      if (Clear) begin
        err_cnt_r <= CNT_W'(1);
      end else if (err_cnt_r == CNT_SAT) begin
        err_cnt_r <= err_cnt_r;
      end else begin
        err_cnt_r <= err_cnt_r + CNT_W'(1);
      end
    end else if (Clear) begin
      sticky_r  <= 1'b0;
      err_cnt_r <= '0;
    end else begin
      sticky_r  <= sticky_r;
      err_cnt_r <= err_cnt_r;
    end
  end

  assign RunErr    = run_err_r;
  assign DispErr   = disp_err_r;
  assign CommaErr  = comma_err_r;
  assign ErrSticky = sticky_r;
  assign RD        = rd_r;
  assign ErrCount  = err_cnt_r;
  assign Active    = active_r;

endmodule
